// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU: single-cycle ops, radix-2 Booth MUL, signed non-restoring DIV
module seq_alu #(
   parameter int WIDTH = 32,
   localparam int SHW = $clog2(WIDTH)
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] C_lo,
   output logic [WIDTH-1:0] C_hi,
   output logic             div0
);

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_SHR  = 5'b00101;
   localparam logic [4:0] OP_SHRA = 5'b00110;
   localparam logic [4:0] OP_SHL  = 5'b00111;
   localparam logic [4:0] OP_ROR  = 5'b01000;
   localparam logic [4:0] OP_ROL  = 5'b01001;
   localparam logic [4:0] OP_AND  = 5'b01010;
   localparam logic [4:0] OP_OR   = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [SHW:0] CNT_END = (SHW+1)'(WIDTH);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_EXEC, S_MUL, S_DIV, S_DFIX, S_DONE
   } state_t;

   state_t state, state_next;

   logic [4:0]       op_r;
   logic [WIDTH-1:0] a_r, b_r;
   logic [SHW:0]     cnt;
   logic [WIDTH:0]   acc;
   logic [WIDTH-1:0] q;
   logic             q_1;
   logic [WIDTH+1:0] rem;
   logic [WIDTH-1:0] dvs;

   logic [WIDTH-1:0]   single_lo, single_hi, fin_lo, fin_hi;
   logic [SHW-1:0]     sh;
   logic [2*WIDTH-1:0] dbl, rot_r, rot_l;
   logic [WIDTH:0]     m_ext, acc_sum;
   logic [WIDTH+1:0]   dv_ext, rem_shift, rem_new, rem_fix;
   logic [WIDTH-1:0]   a_abs, b_abs, quo, rmd;

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b1;
      done       = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_next = S_LOAD;
         end
         // operands captured, busy not yet raised
         S_LOAD: begin
            busy = 1'b0;
            if (op_r == OP_MUL)                           state_next = S_MUL;
            else if (op_r == OP_DIV && b_r != '0)         state_next = S_DIV;
            else                                          state_next = S_EXEC;
         end
         S_EXEC:  state_next = S_DONE;
         S_MUL:   if (cnt == CNT_END) state_next = S_DONE;
         S_DIV:   if (cnt == CNT_END) state_next = S_DFIX;
         S_DFIX:  state_next = S_DONE;
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      sh    = b_r[SHW-1:0];
      dbl   = {a_r, a_r};
      rot_r = dbl >> sh;
      rot_l = dbl << sh;
      single_hi = '0;
      case (op_r)
         OP_ADD:  single_lo = a_r + b_r;
         OP_SUB:  single_lo = a_r - b_r;
         OP_AND:  single_lo = a_r & b_r;
         OP_OR:   single_lo = a_r | b_r;
         OP_SHR:  single_lo = a_r >> sh;
         OP_SHRA: single_lo = $signed(a_r) >>> sh;
         OP_SHL:  single_lo = a_r << sh;
         OP_ROR:  single_lo = rot_r[WIDTH-1:0];
         OP_ROL:  single_lo = rot_l[2*WIDTH-1:WIDTH];
         OP_NEG:  single_lo = '0 - a_r;
         OP_NOT:  single_lo = ~a_r;
         OP_DIV: begin
            single_lo = '1;
            single_hi = a_r;
         end
         default: single_lo = '0;
      endcase
   end

   always_comb begin
      a_abs  = a_r[WIDTH-1] ? ('0 - a_r) : a_r;
      b_abs  = b_r[WIDTH-1] ? ('0 - b_r) : b_r;
      m_ext  = {a_r[WIDTH-1], a_r};
      case ({q[0], q_1})
         2'b01:   acc_sum = acc + m_ext;
         2'b10:   acc_sum = acc - m_ext;
         default: acc_sum = acc;
      endcase
      // non-restoring step: add divisor back when the partial remainder is negative
      dv_ext    = {2'b00, dvs};
      rem_shift = {rem[WIDTH:0], q[WIDTH-1]};
      rem_new   = rem[WIDTH+1] ? (rem_shift + dv_ext) : (rem_shift - dv_ext);
      rem_fix   = rem[WIDTH+1] ? (rem + dv_ext) : rem;
      quo       = (a_r[WIDTH-1] ^ b_r[WIDTH-1]) ? ('0 - q) : q;
      rmd       = a_r[WIDTH-1] ? ('0 - rem_fix[WIDTH-1:0]) : rem_fix[WIDTH-1:0];
      fin_lo    = '0;
      fin_hi    = '0;
      case (state)
         S_EXEC: begin
            fin_lo = single_lo;
            fin_hi = single_hi;
         end
         S_MUL: begin
            fin_lo = q;
            fin_hi = acc[WIDTH-1:0];
         end
         S_DFIX: begin
            fin_lo = quo;
            fin_hi = rmd;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         op_r <= '0;
         a_r  <= '0;
         b_r  <= '0;
         cnt  <= '0;
         acc  <= '0;
         q    <= '0;
         q_1  <= 1'b0;
         rem  <= '0;
         dvs  <= '0;
         C_lo <= '0;
         C_hi <= '0;
         div0 <= 1'b0;
      end else begin
         if (state == S_IDLE && start) begin
            op_r <= op;
            a_r  <= A;
            b_r  <= B;
         end
         if (state == S_LOAD) begin
            cnt <= '0;
            acc <= '0;
            q_1 <= 1'b0;
            rem <= '0;
            dvs <= b_abs;
            q   <= (op_r == OP_DIV) ? a_abs : b_r;
         end
         if (state == S_MUL && cnt != CNT_END) begin
            cnt <= cnt + 1'b1;
            acc <= {acc_sum[WIDTH], acc_sum[WIDTH:1]};
            q   <= {acc_sum[0], q[WIDTH-1:1]};
            q_1 <= q[0];
         end
         if (state == S_DIV && cnt != CNT_END) begin
            cnt <= cnt + 1'b1;
            rem <= rem_new;
            q   <= {q[WIDTH-2:0], ~rem_new[WIDTH+1]};
         end
         if (state_next == S_DONE) begin
            C_lo <= fin_lo;
            C_hi <= fin_hi;
            div0 <= (op_r == OP_DIV) && (b_r == '0);
         end
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed self-checking bench for seq_alu (WIDTH=32)
module tb_seq_alu;

   logic        clock = 1'b0;
   logic        clear = 1'b0;
   logic        start = 1'b0;
   logic [4:0]  op    = '0;
   logic [31:0] A     = '0;
   logic [31:0] B     = '0;
   logic        busy, done, div0;
   logic [31:0] C_lo, C_hi;

   int checks = 0;
   int errors = 0;
   int lat;
   logic busy1;
   int ndone;

   seq_alu #(.WIDTH(32)) dut (
      .clock(clock), .clear(clear), .start(start), .op(op), .A(A), .B(B),
      .busy(busy), .done(done), .C_lo(C_lo), .C_hi(C_hi), .div0(div0)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called #1 after an edge in an IDLE cycle; returns in the done cycle (or after timeout).
   task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int n, output logic b1);
      op = o; A = a; B = b; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      op = 5'b00011; A = 32'h1234_5678; B = 32'h0000_0003;
      n = 0;
      b1 = 1'b0;
      while (!done && n < 100) begin
         @(posedge clock); #1;
         n++;
         if (n == 1) b1 = busy;
      end
   endtask

   task automatic next_idle();
      @(posedge clock); #1;
   endtask

   initial begin
      repeat (3) @(posedge clock);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_out",  {C_hi, C_lo}, 64'd0);
      chk("rst_div0", 64'(div0), 64'd0);
      clear = 1'b1;
      next_idle();

      run_op(5'b00011, 32'hFFFF_FFFF, 32'h1, lat, busy1);
      chk("add_lat", 64'(lat), 64'd2);
      chk("add_busy", 64'(busy1), 64'd1);
      chk("add_res", {C_hi, C_lo}, 64'h0);
      next_idle();
      run_op(5'b00100, 32'd5, 32'd7, lat, busy1);
      chk("sub", {C_hi, C_lo}, 64'h0000_0000_FFFF_FFFE);
      next_idle();
      run_op(5'b00110, 32'h8000_0000, 32'd4, lat, busy1);
      chk("shra", {C_hi, C_lo}, 64'h0000_0000_F800_0000);
      next_idle();
      run_op(5'b01001, 32'h8000_0001, 32'd1, lat, busy1);
      chk("rol", {C_hi, C_lo}, 64'h0000_0000_0000_0003);
      next_idle();
      run_op(5'b01000, 32'h0000_0003, 32'd1, lat, busy1);
      chk("ror", {C_hi, C_lo}, 64'h0000_0000_8000_0001);
      next_idle();
      run_op(5'b00111, 32'h0000_0001, 32'h21, lat, busy1);
      chk("shl_wrapamt", {C_hi, C_lo}, 64'h0000_0000_0000_0002);
      next_idle();
      run_op(5'b00101, 32'h8000_0000, 32'h0, lat, busy1);
      chk("shr_zero", {C_hi, C_lo}, 64'h0000_0000_8000_0000);
      next_idle();
      run_op(5'b10001, 32'h1, 32'h0, lat, busy1);
      chk("neg", {C_hi, C_lo}, 64'h0000_0000_FFFF_FFFF);
      next_idle();
      run_op(5'b10010, 32'h0F0F_0F0F, 32'h0, lat, busy1);
      chk("not", {C_hi, C_lo}, 64'h0000_0000_F0F0_F0F0);
      next_idle();
      run_op(5'b01011, 32'h0F00_00F0, 32'h00F0_0000, lat, busy1);
      chk("or", {C_hi, C_lo}, 64'h0000_0000_0FF0_00F0);
      next_idle();
      run_op(5'b11111, 32'h5, 32'h5, lat, busy1);
      chk("badop_lat", 64'(lat), 64'd2);
      chk("badop", {C_hi, C_lo}, 64'h0);
      next_idle();

      run_op(5'b01111, 32'hFFFF_FFFD, 32'd7, lat, busy1);
      chk("mul_lat", 64'(lat), 64'd34);
      chk("mul_neg", {C_hi, C_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      next_idle();
      run_op(5'b01111, 32'h8000_0000, 32'h8000_0000, lat, busy1);
      chk("mul_min", {C_hi, C_lo}, 64'h4000_0000_0000_0000);
      next_idle();

      run_op(5'b10000, 32'hFFFF_FFF9, 32'd2, lat, busy1);
      chk("div_lat", 64'(lat), 64'd35);
      chk("div_neg", {C_hi, C_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      next_idle();
      run_op(5'b10000, 32'h8000_0000, 32'hFFFF_FFFF, lat, busy1);
      chk("div_minm1", {C_hi, C_lo}, 64'h0000_0000_8000_0000);
      next_idle();

      run_op(5'b10000, 32'd5, 32'd0, lat, busy1);
      chk("div0_lat", 64'(lat), 64'd2);
      chk("div0_flag", 64'(div0), 64'd1);
      chk("div0_res", {C_hi, C_lo}, 64'h0000_0005_FFFF_FFFF);
      next_idle();
      chk("div0_hold", 64'(div0), 64'd1);
      run_op(5'b01010, 32'h0000_F0F0, 32'h0000_FF00, lat, busy1);
      chk("and_res", {C_hi, C_lo}, 64'h0000_0000_0000_F000);
      chk("and_div0clr", 64'(div0), 64'd0);
      next_idle();

      // start held high through a DIV; released in the DONE cycle
      op = 5'b10000; A = 32'd100; B = 32'd7; start = 1'b1;
      ndone = 0;
      lat = 0;
      while (ndone == 0 && lat < 100) begin
         @(posedge clock); #1;
         lat++;
         if (done) ndone++;
      end
      start = 1'b0;
      chk("hold_res", {C_hi, C_lo}, 64'h0000_0002_0000_000E);
      for (int i = 0; i < 40; i++) begin
         @(posedge clock); #1;
         if (done) ndone++;
      end
      chk("hold_onedone", 64'(ndone), 64'd1);

      // back-to-back: second op launched in the IDLE cycle after DONE
      run_op(5'b00011, 32'd10, 32'd20, lat, busy1);
      next_idle();
      run_op(5'b00011, 32'd3, 32'd4, lat, busy1);
      chk("b2b_lat", 64'(lat), 64'd2);
      chk("b2b_res", {C_hi, C_lo}, 64'd7);
      next_idle();

      // set div0 and outputs nonzero, then reset in the middle of a MUL
      run_op(5'b10000, 32'd9, 32'd0, lat, busy1);
      next_idle();
      op = 5'b01111; A = 32'd123; B = 32'd456; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (11) @(posedge clock);
      #1;
      chk("mid_busy_pre", 64'(busy), 64'd1);
      clear = 1'b0;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_out", {C_hi, C_lo}, 64'h0);
      chk("abort_div0", 64'(div0), 64'd0);
      @(posedge clock); #1;
      clear = 1'b1;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock); #1;
         if (done) ndone++;
      end
      chk("abort_nodone", 64'(ndone), 64'd0);
      run_op(5'b00011, 32'd2, 32'd3, lat, busy1);
      chk("post_rst_lat", 64'(lat), 64'd2);
      chk("post_rst_add", {C_hi, C_lo}, 64'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
